calc_sequencer: RTL and testbench

- Instruction-level controller for the team's 8-register, 8-bit simple_calculator datapath (register file plus ALU).
- Accepts one instruction at a time over a valid/ready handshake and drives the calculator's WEN/RW/RX/RY/DataIn/Sel/Ctrl.
- Repeats the ALU operation a programmable number of times, reads back the destination register, and reports the result and carry with a one-cycle Done pulse.
- Sits between the host or test stimulus and the simple_calculator instance.

---
 rtl/calc_sequencer.sv | 105 ++++++++++
 tb/tb_calc_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: instruction sequencer for the 8x8-bit simple_calculator (regfile + ALU).
// Accepts one instruction per valid/ready handshake, runs the ALU write InRep+1 times,
// reads the destination back over busY and pulses Done with Result/CarryFlag.
// Optional macro CARRY_BREAK_EN: a carry-out during EXEC ends the repeat after that write.
module calc_sequencer #(
    parameter int REP_W = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       InCtrl,
    input  logic             InSel,
    input  logic [2:0]       InRW,
    input  logic [2:0]       InRX,
    input  logic [2:0]       InRY,
    input  logic [7:0]       InData,
    input  logic [REP_W-1:0] InRep,
    output logic             WEN,
    output logic [2:0]       RW,
    output logic [2:0]       RX,
    output logic [2:0]       RY,
    output logic [7:0]       DataIn,
    output logic             Sel,
    output logic [3:0]       Ctrl,
    input  logic [7:0]       busY,
    input  logic             Carry,
    output logic [7:0]       Result,
    output logic             CarryFlag,
    output logic             Done,
    output logic             Busy
);

    typedef enum logic [1:0] {IDLE, EXEC, READ, DONE} state_t;

    state_t           state;
    logic [REP_W-1:0] cnt;
    logic [2:0]       ry_lat;
    logic             stop;

`ifdef CARRY_BREAK_EN
    assign stop = (cnt == '0) || Carry;
`else
    assign stop = (cnt == '0);
`endif

    assign InReady = (state == IDLE);
    assign Busy    = (state != IDLE);

    // Sequencer FSM: latch instruction, repeat writes, read destination back, pulse Done.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ry_lat    <= '0;
            WEN       <= 1'b0;
            RW        <= '0;
            RX        <= '0;
            RY        <= '0;
            DataIn    <= '0;
            Sel       <= 1'b0;
            Ctrl      <= '0;
            Result    <= '0;
            CarryFlag <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (InValid) begin
                    RW     <= InRW;
                    RX     <= InRX;
                    RY     <= InRY;
                    ry_lat <= InRY;
                    DataIn <= InData;
                    Sel    <= InSel;
                    Ctrl   <= InCtrl;
                    cnt    <= InRep;
                    WEN    <= 1'b1;
                    state  <= EXEC;
                end
                EXEC: begin
                    CarryFlag <= Carry;
                    if (stop) begin
                        WEN   <= 1'b0;
                        RY    <= RW;
                        state <= READ;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READ: begin
                    Result <= busY;
                    RY     <= ry_lat;
                    Done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: random + directed bench for calc_sequencer with a calculator stub.
// Honors CARRY_BREAK_EN so the reference model matches the build.
module tb_calc_sequencer;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       sel;
        logic [2:0] rw;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] data;
        logic [3:0] rep;
    } instr_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_PASS = 4'd5;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       InValid = 1'b0;
    logic       InReady;
    logic [3:0] InCtrl = '0;
    logic       InSel = 1'b0;
    logic [2:0] InRW = '0, InRX = '0, InRY = '0;
    logic [7:0] InData = '0;
    logic [3:0] InRep = '0;
    logic       WEN;
    logic [2:0] RW, RX, RY;
    logic [7:0] DataIn;
    logic       Sel;
    logic [3:0] Ctrl;
    logic [7:0] busY;
    logic       Carry;
    logic [7:0] Result;
    logic       CarryFlag;
    logic       Done;
    logic       Busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] cregs [8] = '{default: 8'h00};
    logic [7:0] ref_regs [8] = '{default: 8'h00};
    logic [7:0] calc_x;
    logic [8:0] calc_r;

    calc_sequencer #(.REP_W(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
        .InCtrl(InCtrl), .InSel(InSel), .InRW(InRW), .InRX(InRX), .InRY(InRY),
        .InData(InData), .InRep(InRep), .WEN(WEN), .RW(RW), .RX(RX), .RY(RY),
        .DataIn(DataIn), .Sel(Sel), .Ctrl(Ctrl), .busY(busY), .Carry(Carry),
        .Result(Result), .CarryFlag(CarryFlag), .Done(Done), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // ALU of the calculator stub; carry is bit 8 (borrow for SUB).
    function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            4'd0:    return {1'b0, x} + {1'b0, y};
            4'd1:    return {1'b0, x} - {1'b0, y};
            4'd2:    return {1'b0, x & y};
            4'd3:    return {1'b0, x | y};
            4'd4:    return {1'b0, x ^ y};
            default: return {1'b0, x};
        endcase
    endfunction

    assign calc_x = Sel ? cregs[RX] : DataIn;
    assign calc_r = alu(Ctrl, calc_x, cregs[RY]);
    assign busY   = cregs[RY];
    assign Carry  = calc_r[8];

    // Calculator register file: one write per clock while WEN is high.
    always @(posedge Clk) if (WEN) cregs[RW] <= calc_r[7:0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic [3:0] ctrl, input logic sel, input logic [2:0] rw,
                                  input logic [2:0] rx, input logic [2:0] ry,
                                  input logic [7:0] data, input logic [3:0] rep);
        return '{ctrl: ctrl, sel: sel, rw: rw, rx: rx, ry: ry, data: data, rep: rep};
    endfunction

    // Reference: apply the instruction rep+1 times to the model register file.
    task automatic ref_exec(input instr_t i, output int n, output logic c);
        logic [8:0] r;
        n = 0;
        c = 1'b0;
        for (int k = 0; k <= int'(i.rep); k++) begin
            r = alu(i.ctrl, i.sel ? ref_regs[i.rx] : i.data, ref_regs[i.ry]);
            ref_regs[i.rw] = r[7:0];
            c = r[8];
            n++;
`ifdef CARRY_BREAK_EN
            if (c) break;
`endif
        end
    endtask

    task automatic drive(input instr_t i);
        InCtrl = i.ctrl;
        InSel  = i.sel;
        InRW   = i.rw;
        InRX   = i.rx;
        InRY   = i.ry;
        InData = i.data;
        InRep  = i.rep;
    endtask

    // Called at a negedge with InValid high; returns #1 after the accepting edge.
    task automatic accept();
        int w = 0;
        while (!InReady && w < 50) begin
            @(negedge Clk);
            w++;
        end
        chk("accept_wait", 64'(w < 50), 64'd1);
        @(posedge Clk);
        #1;
    endtask

    // Called #1 after the accepting edge; cycle count is from the handshake cycle.
    task automatic finish_instr(input instr_t i);
        int n = 0, wc = 0, iters;
        logic c;
        logic [63:0] rf_dut, rf_ref;
        ref_exec(i, iters, c);
        do begin
            @(negedge Clk);
            n++;
            if (WEN) wc++;
            chk("wen_with_done", 64'(WEN && Done), 64'd0);
            chk("ready_with_done", 64'(InReady && Done), 64'd0);
        end while (!Done && n < 100);
        chk("done_latency", 64'(n), 64'(iters + 2));
        chk("wen_cycles", 64'(wc), 64'(iters));
        chk("result", 64'(Result), 64'(ref_regs[i.rw]));
        chk("carry_flag", 64'(CarryFlag), 64'(c));
        for (int k = 0; k < 8; k++) begin
            rf_dut[k*8 +: 8] = cregs[k];
            rf_ref[k*8 +: 8] = ref_regs[k];
        end
        chk("regfile", rf_dut, rf_ref);
        @(negedge Clk);
        chk("done_one_cycle", 64'(Done), 64'd0);
        chk("ready_after_done", 64'(InReady), 64'd1);
    endtask

    task automatic run(input instr_t i);
        @(negedge Clk);
        drive(i);
        InValid = 1'b1;
        accept();
        InValid = 1'b0;
        finish_instr(i);
    endtask

    initial begin
        instr_t a, b;
        logic seen_done, seen_wen;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(InReady), 64'd1);
        chk("rst_wen", 64'(WEN), 64'd0);
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_carry", 64'(CarryFlag), 64'd0);

        run(mk(OP_PASS, 1'b0, 3'd3, 3'd0, 3'd3, 8'h2A, 4'd0));
        chk("load_imm_r3", 64'(cregs[3]), 64'h2A);

        run(mk(OP_PASS, 1'b0, 3'd1, 3'd0, 3'd1, 8'h05, 4'd0));
        run(mk(OP_ADD, 1'b1, 3'd1, 3'd1, 3'd1, 8'h00, 4'd2));
        chk("accum_r1", 64'(cregs[1]), 64'h28);

        run(mk(OP_PASS, 1'b0, 3'd2, 3'd0, 3'd2, 8'hF0, 4'd0));
        run(mk(OP_PASS, 1'b0, 3'd3, 3'd0, 3'd3, 8'h20, 4'd0));
        run(mk(OP_ADD, 1'b1, 3'd4, 3'd2, 3'd3, 8'h00, 4'd0));
        chk("carry_r4", 64'(cregs[4]), 64'h10);
        chk("carry_flag_set", 64'(CarryFlag), 64'd1);
        run(mk(OP_ADD, 1'b1, 3'd2, 3'd2, 3'd3, 8'h00, 4'd7));

        a = mk(OP_ADD, 1'b0, 3'd6, 3'd0, 3'd6, 8'h03, 4'd1);
        b = mk(OP_ADD, 1'b0, 3'd7, 3'd0, 3'd7, 8'h11, 4'd2);
        @(negedge Clk);
        drive(a);
        InValid = 1'b1;
        accept();
        drive(b);
        finish_instr(a);
        @(posedge Clk);
        #1;
        chk("b2b_accept_wen", 64'(WEN), 64'd1);
        chk("b2b_accept_busy", 64'(Busy), 64'd1);
        InValid = 1'b0;
        finish_instr(b);

        @(negedge Clk);
        drive(mk(OP_ADD, 1'b0, 3'd5, 3'd0, 3'd5, 8'h01, 4'd5));
        InValid = 1'b1;
        accept();
        InValid = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("midrst_wen", 64'(WEN), 64'd0);
        chk("midrst_ready", 64'(InReady), 64'd1);
        chk("midrst_busy", 64'(Busy), 64'd0);
        chk("midrst_result", 64'(Result), 64'd0);
        chk("midrst_carry", 64'(CarryFlag), 64'd0);
        ref_regs[5] = ref_regs[5] + 8'd2;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        seen_done = 1'b0;
        seen_wen = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            seen_done |= Done;
            seen_wen |= WEN;
        end
        chk("midrst_no_done", 64'(seen_done), 64'd0);
        chk("midrst_no_wen", 64'(seen_wen), 64'd0);
        chk("midrst_two_writes", 64'(cregs[5]), 64'(ref_regs[5]));

        for (int t = 0; t < 40; t++) begin
            run(mk(4'($urandom_range(0, 5)), 1'($urandom), 3'($urandom), 3'($urandom),
                   3'($urandom), 8'($urandom), 4'($urandom)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
